rv64g_decode_buffer: RTL and testbench
======================================

Name: rv64g_decode_buffer

Overview:
Registered decode stage between fetch and issue. Accepts one 32-bit instruction word plus PC per cycle over a valid/ready handshake and decodes it combinationally with the RV64G decoder. Stores the decoded command, PC and an illegal flag in a parametrised-depth FIFO, then presents entries to issue over a second valid/ready handshake. Adds what the bare decoder lacks: buffering, back-pressure, flush, illegal/compressed detection and occupancy reporting.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, >= 2
XLEN, 64, PC width

Ports:
clk_i  in  1  clock; all state updates on rising edge
arst_ni  in  1  asynchronous active-low reset
flush_i  in  1  discard all buffered entries (branch mispredict/trap)
code_i  in  32  raw instruction word
pc_i  in  XLEN  PC of code_i
in_valid_i  in  1  code_i/pc_i valid
in_ready_o  out  1  buffer can accept
cmd_o  out  decoded_instr_t  head entry decoded command
pc_o  out  XLEN  head entry PC
illegal_o  out  1  head entry is illegal
out_valid_o  out  1  head entry valid
out_ready_i  in  1  issue consumes head
count_o  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (arst_ni low, asynchronous): wr_ptr=rd_ptr=0, count=0; out_valid_o=0, in_ready_o=1, count_o=0. cmd_o, pc_o and illegal_o read 0 while empty (masked, not just don't-care).
- Push = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.
- in_ready_o = (count < DEPTH). It is registered-state-only, with no combinational path from out_ready_i. When full, a simultaneous pop does not allow a push that cycle.
- out_valid_o = (count != 0). Head outputs are driven straight from storage at rd_ptr. Latency from push into an empty buffer to out_valid_o high is 1 cycle. No bypass.
- Push and pop in the same cycle when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. count is a separate counter of width $clog2(DEPTH+1).
- Illegal detection at push: illegal = (code_i[1:0] != 2'b11) | (decoded funct == INVALID). The compressed case is flagged because C is not supported. Illegal entries are still stored with cmd = '0 and the real PC, so the trap can be raised in order.
- Flush: next edge sets count=0, rd_ptr=wr_ptr=0. Flush has priority over push and pop in the same cycle; the pushed word is dropped and the pop is ignored by the buffer. Issue must qualify any pop with !flush_i.
- Reset asserted mid-operation clears all state immediately. No entry survives.
- No state machine beyond the FIFO. Storage holds flops, not RAM, so reads are zero-latency.

Optional Feature:
RV64G_DECODE_BUFFER_STATS_EN
- Defined: adds ports stat_accepted_o[31:0] and stat_illegal_o[31:0]. These are saturating counters of pushes and of illegal pushes. They reset to 0 on arst_ni, are unaffected by flush_i, and hold at 32'hFFFF_FFFF once reached.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- rv64g_pkg gains decode_entry_t = {decoded_instr_t cmd; logic [63:0] pc; logic illegal}. The block stores only XLEN bits of pc.
- The decoded_instr_t and funct enums (INVALID, JAL, LUI, ECALL, ...) are reused from rv64g_pkg unchanged.
- One sub-module: instruction_decoder, instantiated once on the push path (combinational). FIFO logic stays inline.

Test Plan:
- Reset then push 32'h123452B7 at pc 0x1000 → next cycle out_valid_o=1, cmd_o.funct=LUI, rd=5, imm[31:12]=0x12345, pc_o=0x1000, illegal_o=0, count_o=1.
- Push 32'h0000006F, 32'h00000073, 32'h00100073, 32'h0000006F with out_ready_i=0 → count_o=4, in_ready_o=0. Pop 4 → JAL, ECALL, EBREAK, JAL in order; count_o returns to 0 and out_valid_o=0.
- Push 32'h00004501 (compressed) and 32'h0000707F (unmatched) → both popped with illegal_o=1, cmd_o='0, and their PCs intact.
- Full buffer with flush_i=1 while in_valid_i=1 and out_ready_i=1 → next cycle count_o=0, out_valid_o=0, and the flushed-cycle word is never output.
- Continuous push and pop for 10 cycles with DEPTH=4 → count_o steady at 1, pointers wrap, PCs 0x0..0x24 (step 4) emerge in order.
- With RV64G_DECODE_BUFFER_STATS_EN: 3 legal and 2 illegal pushes, then a flush → stat_accepted_o=5 and stat_illegal_o=2, both unchanged by the flush.

Source files
------------

// File: rtl/rv64g_pkg.sv
// Shared RV64G decode types: instruction function enum, decoded command and
// buffered entry layouts, and the major opcode constants used by the decoder.
package rv64g_pkg;

  typedef enum logic [6:0] {
    INVALID,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LD, LBU, LHU, LWU,
    SB, SH, SW, SD,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ADDIW, SLLIW, SRLIW, SRAIW,
    ADDW, SUBW, SLLW, SRLW, SRAW,
    FENCE, FENCE_I, ECALL, EBREAK,
    CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    MULW, DIVW, DIVUW, REMW, REMUW,
    LR_W, SC_W, AMOSWAP_W, AMOADD_W, AMOXOR_W, AMOAND_W, AMOOR_W,
    AMOMIN_W, AMOMAX_W, AMOMINU_W, AMOMAXU_W,
    LR_D, SC_D, AMOSWAP_D, AMOADD_D, AMOXOR_D, AMOAND_D, AMOOR_D,
    AMOMIN_D, AMOMAX_D, AMOMINU_D, AMOMAXU_D,
    FLW, FLD, FSW, FSD
  } funct_t;

  typedef struct packed {
    funct_t      funct;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
  } decoded_instr_t;

  typedef struct packed {
    decoded_instr_t cmd;
    logic [63:0]    pc;
    logic           illegal;
  } decode_entry_t;

  localparam logic [1:0] UNCOMPRESSED = 2'b11;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM32    = 7'b0011011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] OP_REG32    = 7'b0111011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_AMO      = 7'b0101111;
  localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OP_STORE_FP = 7'b0100111;

endpackage

// File: rtl/rv64g_decode_buffer_decoder.sv
// instruction_decoder: purely combinational 32-bit decode into decoded_instr_t.
// Unrecognised encodings report funct = INVALID.
module instruction_decoder
  import rv64g_pkg::*;
(
  input  logic [31:0]    code_i,
  output decoded_instr_t cmd_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [63:0] i_imm, s_imm, b_imm, u_imm, j_imm, sh_imm, shw_imm, csr_imm;
  funct_t      funct;
  logic [63:0] imm;

  assign opcode  = code_i[6:0];
  assign f3      = code_i[14:12];
  assign f7      = code_i[31:25];
  assign i_imm   = {{52{code_i[31]}}, code_i[31:20]};
  assign s_imm   = {{52{code_i[31]}}, code_i[31:25], code_i[11:7]};
  assign b_imm   = {{51{code_i[31]}}, code_i[31], code_i[7], code_i[30:25], code_i[11:8], 1'b0};
  assign u_imm   = {{32{code_i[31]}}, code_i[31:12], 12'b0};
  assign j_imm   = {{43{code_i[31]}}, code_i[31], code_i[19:12], code_i[20], code_i[30:21], 1'b0};
  assign sh_imm  = {58'b0, code_i[25:20]};
  assign shw_imm = {59'b0, code_i[24:20]};
  assign csr_imm = {52'b0, code_i[31:20]};

  always_comb begin
    funct = INVALID;
    imm   = '0;
    case (opcode)
      OP_LUI:   begin funct = LUI;   imm = u_imm; end
      OP_AUIPC: begin funct = AUIPC; imm = u_imm; end
      OP_JAL:   begin funct = JAL;   imm = j_imm; end
      OP_JALR:  begin imm = i_imm; if (f3 == 3'd0) funct = JALR; end
      OP_BRANCH: begin
        imm = b_imm;
        case (f3)
          3'd0: funct = BEQ;  3'd1: funct = BNE;
          3'd4: funct = BLT;  3'd5: funct = BGE;
          3'd6: funct = BLTU; 3'd7: funct = BGEU;
          default: funct = INVALID;
        endcase
      end
      OP_LOAD: begin
        imm = i_imm;
        case (f3)
          3'd0: funct = LB;  3'd1: funct = LH;  3'd2: funct = LW; 3'd3: funct = LD;
          3'd4: funct = LBU; 3'd5: funct = LHU; 3'd6: funct = LWU;
          default: funct = INVALID;
        endcase
      end
      OP_STORE: begin
        imm = s_imm;
        case (f3)
          3'd0: funct = SB; 3'd1: funct = SH; 3'd2: funct = SW; 3'd3: funct = SD;
          default: funct = INVALID;
        endcase
      end
      OP_IMM: begin
        imm = i_imm;
        case (f3)
          3'd0: funct = ADDI;  3'd2: funct = SLTI; 3'd3: funct = SLTIU;
          3'd4: funct = XORI;  3'd6: funct = ORI;  3'd7: funct = ANDI;
          3'd1: begin imm = sh_imm; if (code_i[31:26] == 6'b000000) funct = SLLI; end
          3'd5: begin
            imm = sh_imm;
            if (code_i[31:26] == 6'b000000) funct = SRLI;
            else if (code_i[31:26] == 6'b010000) funct = SRAI;
          end
          default: funct = INVALID;
        endcase
      end
      OP_IMM32: begin
        imm = i_imm;
        case (f3)
          3'd0: funct = ADDIW;
          3'd1: begin imm = shw_imm; if (f7 == 7'b0000000) funct = SLLIW; end
          3'd5: begin
            imm = shw_imm;
            if (f7 == 7'b0000000) funct = SRLIW;
            else if (f7 == 7'b0100000) funct = SRAIW;
          end
          default: funct = INVALID;
        endcase
      end
      OP_REG: begin
        case ({f7, f3})
          10'b0000000_000: funct = ADD;    10'b0000000_001: funct = SLL;
          10'b0000000_010: funct = SLT;    10'b0000000_011: funct = SLTU;
          10'b0000000_100: funct = XOR;    10'b0000000_101: funct = SRL;
          10'b0000000_110: funct = OR;     10'b0000000_111: funct = AND;
          10'b0100000_000: funct = SUB;    10'b0100000_101: funct = SRA;
          10'b0000001_000: funct = MUL;    10'b0000001_001: funct = MULH;
          10'b0000001_010: funct = MULHSU; 10'b0000001_011: funct = MULHU;
          10'b0000001_100: funct = DIV;    10'b0000001_101: funct = DIVU;
          10'b0000001_110: funct = REM;    10'b0000001_111: funct = REMU;
          default: funct = INVALID;
        endcase
      end
      OP_REG32: begin
        case ({f7, f3})
          10'b0000000_000: funct = ADDW;  10'b0000000_001: funct = SLLW;
          10'b0000000_101: funct = SRLW;  10'b0100000_000: funct = SUBW;
          10'b0100000_101: funct = SRAW;  10'b0000001_000: funct = MULW;
          10'b0000001_100: funct = DIVW;  10'b0000001_101: funct = DIVUW;
          10'b0000001_110: funct = REMW;  10'b0000001_111: funct = REMUW;
          default: funct = INVALID;
        endcase
      end
      OP_MISC_MEM: begin
        imm = i_imm;
        if (f3 == 3'd0) funct = FENCE;
        else if (f3 == 3'd1) funct = FENCE_I;
      end
      OP_SYSTEM: begin
        if (code_i == 32'h0000_0073) funct = ECALL;
        else if (code_i == 32'h0010_0073) funct = EBREAK;
        else begin
          imm = csr_imm;
          case (f3)
            3'd1: funct = CSRRW;  3'd2: funct = CSRRS;  3'd3: funct = CSRRC;
            3'd5: funct = CSRRWI; 3'd6: funct = CSRRSI; 3'd7: funct = CSRRCI;
            default: funct = INVALID;
          endcase
        end
      end
      OP_AMO: begin
        // funct3 = 2 selects the .W form, 3 the .D form; LR requires rs2 = 0
        if (f3 == 3'd2 || f3 == 3'd3) begin
          case (code_i[31:27])
            5'b00010: if (code_i[24:20] == 5'd0) funct = f3[0] ? LR_D : LR_W;
            5'b00011: funct = f3[0] ? SC_D      : SC_W;
            5'b00001: funct = f3[0] ? AMOSWAP_D : AMOSWAP_W;
            5'b00000: funct = f3[0] ? AMOADD_D  : AMOADD_W;
            5'b00100: funct = f3[0] ? AMOXOR_D  : AMOXOR_W;
            5'b01100: funct = f3[0] ? AMOAND_D  : AMOAND_W;
            5'b01000: funct = f3[0] ? AMOOR_D   : AMOOR_W;
            5'b10000: funct = f3[0] ? AMOMIN_D  : AMOMIN_W;
            5'b10100: funct = f3[0] ? AMOMAX_D  : AMOMAX_W;
            5'b11000: funct = f3[0] ? AMOMINU_D : AMOMINU_W;
            5'b11100: funct = f3[0] ? AMOMAXU_D : AMOMAXU_W;
            default:  funct = INVALID;
          endcase
        end
      end
      OP_LOAD_FP: begin
        imm = i_imm;
        if (f3 == 3'd2) funct = FLW;
        else if (f3 == 3'd3) funct = FLD;
      end
      OP_STORE_FP: begin
        imm = s_imm;
        if (f3 == 3'd2) funct = FSW;
        else if (f3 == 3'd3) funct = FSD;
      end
      default: funct = INVALID;
    endcase
  end

  assign cmd_o = '{funct: funct, rd: code_i[11:7], rs1: code_i[19:15],
                   rs2: code_i[24:20], imm: imm};

endmodule

// File: rtl/rv64g_decode_buffer.sv
// Registered decode stage: decodes on push, buffers entries in a flop FIFO,
// presents the head to issue. Define RV64G_DECODE_BUFFER_STATS_EN for push counters.
module rv64g_decode_buffer
  import rv64g_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       flush_i,
  input  logic [31:0]                code_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output decoded_instr_t             cmd_o,
  output logic [XLEN-1:0]            pc_o,
  output logic                       illegal_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef RV64G_DECODE_BUFFER_STATS_EN
  ,
  output logic [31:0]                stat_accepted_o,
  output logic [31:0]                stat_illegal_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]  wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]  count_reg, count_next;
  logic           push, pop, wr_en;
  decoded_instr_t dec_cmd;
  decode_entry_t  push_entry;

  decoded_instr_t  cmd_arr [DEPTH];
  logic [XLEN-1:0] pc_arr  [DEPTH];
  logic            ill_arr [DEPTH];

  instruction_decoder u_decoder (
    .code_i (code_i),
    .cmd_o  (dec_cmd)
  );

  // Illegal words keep their PC but carry an all-zero command
  always_comb begin
    push_entry.illegal = (code_i[1:0] != UNCOMPRESSED) || (dec_cmd.funct == INVALID);
    push_entry.cmd     = push_entry.illegal ? '0 : dec_cmd;
    push_entry.pc      = 64'(pc_i);
  end

  assign in_ready_o  = (count_reg < CW'(DEPTH));
  assign out_valid_o = (count_reg != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign wr_en       = push && !flush_i;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    decoded_instr_t  cmd_reg;
    logic [XLEN-1:0] pc_reg;
    logic            ill_reg;

    always_ff @(posedge clk_i) begin
      if (wr_en && (wr_ptr_reg == PW'(gi))) begin
        cmd_reg <= push_entry.cmd;
        pc_reg  <= push_entry.pc[XLEN-1:0];
        ill_reg <= push_entry.illegal;
      end
    end

    assign cmd_arr[gi] = cmd_reg;
    assign pc_arr[gi]  = pc_reg;
    assign ill_arr[gi] = ill_reg;
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      if (push && !pop)      count_next = count_reg + 1'b1;
      else if (pop && !push) count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Head fields are forced to zero while empty so stale storage never leaks
  assign cmd_o     = out_valid_o ? cmd_arr[rd_ptr_reg] : '0;
  assign pc_o      = out_valid_o ? pc_arr[rd_ptr_reg]  : '0;
  assign illegal_o = out_valid_o && ill_arr[rd_ptr_reg];
  assign count_o   = count_reg;

`ifdef RV64G_DECODE_BUFFER_STATS_EN
  logic [31:0] stat_accepted_reg, stat_illegal_reg;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      stat_accepted_reg <= '0;
      stat_illegal_reg  <= '0;
    end else if (push) begin
      if (stat_accepted_reg != '1) stat_accepted_reg <= stat_accepted_reg + 1'b1;
      if (push_entry.illegal && (stat_illegal_reg != '1))
        stat_illegal_reg <= stat_illegal_reg + 1'b1;
    end
  end

  assign stat_accepted_o = stat_accepted_reg;
  assign stat_illegal_o  = stat_illegal_reg;
`endif

endmodule

// File: tb/tb_rv64g_decode_buffer.sv
// Scoreboard bench for rv64g_decode_buffer: expectations queued at push,
// compared by a monitor at every pop; scenario tasks check occupancy inline.
module tb_rv64g_decode_buffer;
  import rv64g_pkg::*;

  typedef struct {
    funct_t      funct;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [63:0] pc;
    logic        illegal;
  } exp_t;

  logic           clk_i = 1'b0;
  logic           arst_ni = 1'b0;
  logic           flush_i = 1'b0;
  logic [31:0]    code_i = '0;
  logic [63:0]    pc_i = '0;
  logic           in_valid_i = 1'b0;
  logic           in_ready_o;
  decoded_instr_t cmd_o;
  logic [63:0]    pc_o;
  logic           illegal_o;
  logic           out_valid_o;
  logic           out_ready_i = 1'b0;
  logic [2:0]     count_o;
`ifdef RV64G_DECODE_BUFFER_STATS_EN
  logic [31:0]    stat_accepted_o, stat_illegal_o;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  rv64g_decode_buffer #(.DEPTH(4), .XLEN(64)) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .flush_i     (flush_i),
    .code_i      (code_i),
    .pc_i        (pc_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .cmd_o       (cmd_o),
    .pc_o        (pc_o),
    .illegal_o   (illegal_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .count_o     (count_o)
`ifdef RV64G_DECODE_BUFFER_STATS_EN
    ,
    .stat_accepted_o (stat_accepted_o),
    .stat_illegal_o  (stat_illegal_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every accepted pop (not masked by flush) must match the queue head
  always @(negedge clk_i) begin
    exp_t e;
    if (arst_ni && out_valid_o && out_ready_i && !flush_i) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected pc=%h funct=%0d", pc_o, cmd_o.funct);
      end else begin
        e = sb_q.pop_front();
        if (cmd_o.funct !== e.funct || cmd_o.rd !== e.rd || cmd_o.imm !== e.imm ||
            pc_o !== e.pc || illegal_o !== e.illegal || (e.illegal && cmd_o !== '0)) begin
          failures++;
          $display("FAIL pop_entry got funct=%0d rd=%0d imm=%h pc=%h ill=%b want funct=%0d rd=%0d imm=%h pc=%h ill=%b",
                   cmd_o.funct, cmd_o.rd, cmd_o.imm, pc_o, illegal_o,
                   e.funct, e.rd, e.imm, e.pc, e.illegal);
        end else begin
          $display("pop  pc=%h funct=%0d rd=%0d ill=%b", pc_o, cmd_o.funct, cmd_o.rd, illegal_o);
        end
      end
    end
  end

  function automatic exp_t mk(funct_t f, logic [4:0] rd, logic [63:0] imm,
                              logic [63:0] pc, logic ill);
    exp_t e;
    e.funct = f; e.rd = rd; e.imm = imm; e.pc = pc; e.illegal = ill;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Drives one cycle; queues the expectation only if the buffer will accept it
  task automatic drive(input logic v, input logic [31:0] code, input logic [63:0] pc,
                       input exp_t e, input logic ordy, input logic fl);
    in_valid_i  = v;
    code_i      = code;
    pc_i        = pc;
    out_ready_i = ordy;
    flush_i     = fl;
    if (v && in_ready_o && !fl) begin
      sb_q.push_back(e);
      $display("push pc=%h code=%h", pc, code);
    end
    tick();
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic idle_pop(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 64'h0, mk(INVALID, 5'd0, 64'h0, 64'h0, 1'b0), 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    arst_ni = 1'b0;
    tick(); tick();
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || count_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_ctrl got valid=%b ready=%b count=%0d want 0 1 0", out_valid_o, in_ready_o, count_o);
    end
    checks++;
    if (cmd_o !== '0 || pc_o !== 64'h0 || illegal_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_head got cmd=%h pc=%h ill=%b want all zero", cmd_o, pc_o, illegal_o);
    end
    arst_ni = 1'b1;
    tick();
    sb_q.delete();
  endtask

  task automatic test_lui();
    checks++;
    if (out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL lui_pre_valid got %b want 0", out_valid_o);
    end
    drive(1'b1, 32'h123452B7, 64'h1000, mk(LUI, 5'd5, 64'h12345000, 64'h1000, 1'b0), 1'b0, 1'b0);
    checks++;
    if (out_valid_o !== 1'b1 || count_o !== 3'd1 || cmd_o.funct !== LUI || cmd_o.rd !== 5'd5 ||
        cmd_o.imm[31:12] !== 20'h12345 || pc_o !== 64'h1000 || illegal_o !== 1'b0) begin
      failures++;
      $display("FAIL lui_head got valid=%b count=%0d funct=%0d rd=%0d imm=%h pc=%h ill=%b want 1 1 LUI 5 12345000 1000 0",
               out_valid_o, count_o, cmd_o.funct, cmd_o.rd, cmd_o.imm, pc_o, illegal_o);
    end
    idle_pop(1);
    checks++;
    if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL lui_drain got count=%0d valid=%b want 0 0", count_o, out_valid_o);
    end
  endtask

  task automatic test_fill_drain();
    drive(1'b1, 32'h0000006F, 64'h100, mk(JAL,    5'd0, 64'h0, 64'h100, 1'b0), 1'b0, 1'b0);
    drive(1'b1, 32'h00000073, 64'h104, mk(ECALL,  5'd0, 64'h0, 64'h104, 1'b0), 1'b0, 1'b0);
    drive(1'b1, 32'h00100073, 64'h108, mk(EBREAK, 5'd0, 64'h0, 64'h108, 1'b0), 1'b0, 1'b0);
    drive(1'b1, 32'h0000006F, 64'h10C, mk(JAL,    5'd0, 64'h0, 64'h10C, 1'b0), 1'b0, 1'b0);
    checks++;
    if (count_o !== 3'd4 || in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL full got count=%0d ready=%b want 4 0", count_o, in_ready_o);
    end
    // Full: a pop in the same cycle must not open a slot for the offered word
    drive(1'b1, 32'h00000013, 64'h3000, mk(ADDI, 5'd0, 64'h0, 64'h3000, 1'b0), 1'b1, 1'b0);
    checks++;
    if (count_o !== 3'd3) begin
      failures++;
      $display("FAIL full_pop_no_push got count=%0d want 3", count_o);
    end
    idle_pop(3);
    checks++;
    if (count_o !== 3'd0 || out_valid_o !== 1'b0 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain got count=%0d valid=%b pending=%0d want 0 0 0", count_o, out_valid_o, sb_q.size());
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h00004501, 64'h2000, mk(INVALID, 5'd0, 64'h0, 64'h2000, 1'b1), 1'b0, 1'b0);
    drive(1'b1, 32'h0000707F, 64'h2004, mk(INVALID, 5'd0, 64'h0, 64'h2004, 1'b1), 1'b0, 1'b0);
    checks++;
    if (illegal_o !== 1'b1 || cmd_o !== '0 || pc_o !== 64'h2000) begin
      failures++;
      $display("FAIL illegal_head got ill=%b cmd=%h pc=%h want 1 0 2000", illegal_o, cmd_o, pc_o);
    end
    idle_pop(2);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++)
      drive(1'b1, 32'h0000006F, 64'(32'h4000 + 4 * i), mk(JAL, 5'd0, 64'h0, 64'(32'h4000 + 4 * i), 1'b0), 1'b0, 1'b0);
    drive(1'b1, 32'h00100073, 64'h4444, mk(EBREAK, 5'd0, 64'h0, 64'h4444, 1'b0), 1'b1, 1'b1);
    sb_q.delete();
    checks++;
    if (count_o !== 3'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL flush got count=%0d valid=%b ready=%b want 0 0 1", count_o, out_valid_o, in_ready_o);
    end
    // Flushing while not full must also drop the same-cycle push
    drive(1'b1, 32'h0000006F, 64'h4500, mk(JAL, 5'd0, 64'h0, 64'h4500, 1'b0), 1'b0, 1'b0);
    drive(1'b1, 32'h00100073, 64'h4504, mk(EBREAK, 5'd0, 64'h0, 64'h4504, 1'b0), 1'b0, 1'b1);
    sb_q.delete();
    checks++;
    if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_partial got count=%0d valid=%b want 0 0", count_o, out_valid_o);
    end
    drive(1'b1, 32'h123452B7, 64'h5000, mk(LUI, 5'd5, 64'h12345000, 64'h5000, 1'b0), 1'b0, 1'b0);
    idle_pop(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] code;
    for (int i = 0; i < 10; i++) begin
      code = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
      drive(1'b1, code, 64'(4 * i), mk(ADDI, 5'(i + 1), 64'(i), 64'(4 * i), 1'b0), 1'b1, 1'b0);
      checks++;
      if (count_o !== 3'd1) begin
        failures++;
        $display("FAIL b2b_count cycle=%0d got %0d want 1", i, count_o);
      end
    end
    idle_pop(1);
    checks++;
    if (count_o !== 3'd0 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain got count=%0d pending=%0d want 0 0", count_o, sb_q.size());
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h0000006F, 64'h6000, mk(JAL, 5'd0, 64'h0, 64'h6000, 1'b0), 1'b0, 1'b0);
    drive(1'b1, 32'h0000006F, 64'h6004, mk(JAL, 5'd0, 64'h0, 64'h6004, 1'b0), 1'b0, 1'b0);
    arst_ni = 1'b0;
    #1;
    sb_q.delete();
    checks++;
    if (count_o !== 3'd0 || out_valid_o !== 1'b0 || pc_o !== 64'h0) begin
      failures++;
      $display("FAIL async_reset got count=%0d valid=%b pc=%h want 0 0 0", count_o, out_valid_o, pc_o);
    end
    tick();
    arst_ni = 1'b1;
    tick();
  endtask

`ifdef RV64G_DECODE_BUFFER_STATS_EN
  task automatic test_stats();
    arst_ni = 1'b0;
    #1;
    tick();
    arst_ni = 1'b1;
    tick();
    sb_q.delete();
    drive(1'b1, 32'h00100093, 64'h7000, mk(ADDI, 5'd1, 64'h1, 64'h7000, 1'b0), 1'b1, 1'b0);
    drive(1'b1, 32'h00004501, 64'h7004, mk(INVALID, 5'd0, 64'h0, 64'h7004, 1'b1), 1'b1, 1'b0);
    drive(1'b1, 32'h00200113, 64'h7008, mk(ADDI, 5'd2, 64'h2, 64'h7008, 1'b0), 1'b1, 1'b0);
    drive(1'b1, 32'h0000707F, 64'h700C, mk(INVALID, 5'd0, 64'h0, 64'h700C, 1'b1), 1'b1, 1'b0);
    drive(1'b1, 32'h0000006F, 64'h7010, mk(JAL, 5'd0, 64'h0, 64'h7010, 1'b0), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 64'h0, mk(INVALID, 5'd0, 64'h0, 64'h0, 1'b0), 1'b0, 1'b1);
    sb_q.delete();
    checks++;
    if (stat_accepted_o !== 32'd5 || stat_illegal_o !== 32'd2) begin
      failures++;
      $display("FAIL stats got accepted=%0d illegal=%0d want 5 2", stat_accepted_o, stat_illegal_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lui();
    test_fill_drain();
    test_illegal();
    test_flush();
    test_back_to_back();
    test_async_reset();
`ifdef RV64G_DECODE_BUFFER_STATS_EN
    test_stats();
`endif
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
